// File: rtl/robo_controlador_if.sv
// Sensor/command bundle between the maze memory and the navigation controller.
// The memory reports what it sees around the robot; the controller answers with one-cycle actions.
interface robo_controlador_if;
  logic head;
  logic left;
  logic under;
  logic barrier;
  logic avancar;
  logic girar;
  logic remover;

  modport master (
    input  head, left, under, barrier,
    output avancar, girar, remover
  );

  modport slave (
    output head, left, under, barrier,
    input  avancar, girar, remover
  );
endinterface

// File: rtl/robo_controlador.sv
// Left-hand wall-following navigation FSM with barrier demolition, exit detection and a move budget.
// Every command burst is followed by one quiet SETTLE cycle so the next decision sees updated sensors.
module robo_controlador #(
  parameter int                MOVE_W        = 10,
  parameter logic [MOVE_W-1:0] MAX_MOVES     = MOVE_W'(1000),
  parameter int unsigned       REMOVE_CYCLES = 3,
  parameter int unsigned       RIGHT_PULSES  = 3
) (
  input  logic                  selected_clock,
  input  logic                  reset,
  input  logic                  enable,
  robo_controlador_if.master    bus,
  output logic                  done,
  output logic                  stuck,
  output logic [MOVE_W-1:0]     moves
);

  localparam int unsigned SUB_MAX = (REMOVE_CYCLES > RIGHT_PULSES) ? REMOVE_CYCLES : RIGHT_PULSES;
  localparam int          SUB_W   = $clog2(SUB_MAX + 1);

  typedef enum logic [3:0] {
    IDLE,
    DECIDE,
    TURN_L,
    FWD,
    TURN_R,
    REMOVE,
    SETTLE,
    DONE,
    FAIL
  } state_t;

  state_t             state_q, state_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic               just_left_q, just_left_d;
  logic [MOVE_W-1:0]  moves_q, moves_d;
  logic               done_q, done_d;
  logic               stuck_q, stuck_d;
  logic               avancar_q, avancar_d;
  logic               girar_q, girar_d;
  logic               remover_q, remover_d;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values computed before the edge regardless of statement order.
  always_ff @(posedge selected_clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sub_q       <= '0;
      just_left_q <= 1'b0;
      moves_q     <= '0;
      done_q      <= 1'b0;
      stuck_q     <= 1'b0;
      avancar_q   <= 1'b0;
      girar_q     <= 1'b0;
      remover_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      just_left_q <= just_left_d;
      moves_q     <= moves_d;
      done_q      <= done_d;
      stuck_q     <= stuck_d;
      avancar_q   <= avancar_d;
      girar_q     <= girar_d;
      remover_q   <= remover_d;
    end
  end

  // NOTE: every signal written here gets a default first; a path that forgets one
  // would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    just_left_d = just_left_q;
    moves_d     = moves_q;
    done_d      = done_q;
    stuck_d     = stuck_q;
    avancar_d   = 1'b0;
    girar_d     = 1'b0;
    remover_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = DECIDE;
      end

      DECIDE: begin
        // Priority order matters: exit beats budget, budget beats the enable gate.
        if (bus.under) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (moves_q == MAX_MOVES) begin
          state_d = FAIL;
          stuck_d = 1'b1;
        end else if (!enable) begin
          state_d = DECIDE;
        end else if (bus.barrier) begin
          state_d   = REMOVE;
          remover_d = 1'b1;
          sub_d     = SUB_W'(1);
        end else if (!bus.left && !just_left_q) begin
          state_d     = TURN_L;
          girar_d     = 1'b1;
          just_left_d = 1'b1;
        end else if (!bus.head) begin
          state_d     = FWD;
          avancar_d   = 1'b1;
          moves_d     = (moves_q == MAX_MOVES) ? moves_q : moves_q + MOVE_W'(1);
          just_left_d = 1'b0;
        end else begin
          state_d     = TURN_R;
          girar_d     = 1'b1;
          sub_d       = SUB_W'(1);
          just_left_d = 1'b0;
        end
      end

      TURN_L, FWD: begin
        state_d = SETTLE;
      end

      TURN_R: begin
        // A right turn is three left rotations issued back to back.
        if (sub_q < SUB_W'(RIGHT_PULSES)) begin
          girar_d = 1'b1;
          sub_d   = sub_q + SUB_W'(1);
        end else begin
          sub_d   = '0;
          state_d = SETTLE;
        end
      end

      REMOVE: begin
        if (sub_q < SUB_W'(REMOVE_CYCLES)) begin
          remover_d = 1'b1;
          sub_d     = sub_q + SUB_W'(1);
        end else begin
          sub_d   = '0;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        state_d = DECIDE;
      end

      DONE, FAIL: begin
        state_d = state_q;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.avancar = avancar_q;
  assign bus.girar   = girar_q;
  assign bus.remover = remover_q;
  assign done        = done_q;
  assign stuck       = stuck_q;
  assign moves       = moves_q;

endmodule

// File: tb/tb_robo_controlador.sv
// Directed bench for robo_controlador: exit, corridor/timeout, left opening, dead end, barrier and async reset.
// Commands are compared as the packed vector {avancar, girar, remover}.
module tb_robo_controlador;

  logic       selected_clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       done;
  logic       stuck;
  logic [9:0] moves;
  int         checks   = 0;
  int         failures = 0;

  robo_controlador_if bus ();

  robo_controlador #(
    .MOVE_W        (10),
    .MAX_MOVES     (10'd4),
    .REMOVE_CYCLES (3),
    .RIGHT_PULSES  (3)
  ) dut (
    .selected_clock (selected_clock),
    .reset          (reset),
    .enable         (enable),
    .bus            (bus.master),
    .done           (done),
    .stuck          (stuck),
    .moves          (moves)
  );

  always #5 selected_clock = ~selected_clock;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cmd();
    return 32'({bus.avancar, bus.girar, bus.remover});
  endfunction

  task automatic tick();
    @(posedge selected_clock);
    #1;
  endtask

  task automatic sensors(input logic h, input logic l, input logic u, input logic b);
    bus.head    = h;
    bus.left    = l;
    bus.under   = u;
    bus.barrier = b;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    sensors(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Exit at start: done at the 2nd edge after enable, no commands ever.
    do_reset();
    check("rst_cmd", cmd(), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_stuck", 32'(stuck), 32'h0);
    check("rst_moves", 32'(moves), 32'h0);
    sensors(1'b0, 1'b0, 1'b1, 1'b0);
    enable = 1'b1;
    tick();
    check("exit_e1_done", 32'(done), 32'h0);
    tick();
    check("exit_e2_done", 32'(done), 32'h1);
    check("exit_e2_cmd", cmd(), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("exit_hold_cmd", cmd(), 32'h0);
      check("exit_hold_done", 32'(done), 32'h1);
    end
    check("exit_moves", 32'(moves), 32'h0);

    // Corridor: FWD / SETTLE / DECIDE repeating, then budget of 4 exhausted.
    do_reset();
    sensors(1'b0, 1'b1, 1'b0, 1'b0);
    enable = 1'b1;
    tick();
    check("cor_decide_cmd", cmd(), 32'h0);
    for (int m = 1; m <= 4; m++) begin
      tick();
      check("cor_fwd_cmd", cmd(), 32'h4);
      check("cor_moves", 32'(moves), 32'(m));
      tick();
      check("cor_settle_cmd", cmd(), 32'h0);
      tick();
      check("cor_decide_cmd", cmd(), 32'h0);
    end
    check("cor_stuck_pre", 32'(stuck), 32'h0);
    tick();
    check("cor_stuck", 32'(stuck), 32'h1);
    check("cor_stuck_cmd", cmd(), 32'h0);
    check("cor_stuck_moves", 32'(moves), 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cor_fail_hold", 32'({stuck, done, bus.avancar, bus.girar, bus.remover}), 32'h10);
    end
    check("cor_fail_moves", 32'(moves), 32'h4);

    // Left opening: one left turn, then a forward move despite left still open.
    do_reset();
    sensors(1'b0, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    tick();
    tick();
    check("left_turn", cmd(), 32'h2);
    tick();
    check("left_settle", cmd(), 32'h0);
    tick();
    check("left_decide", cmd(), 32'h0);
    tick();
    check("left_fwd", cmd(), 32'h4);
    check("left_moves", 32'(moves), 32'h1);
    tick();
    tick();
    tick();
    check("left_turn_again", cmd(), 32'h2);

    // Dead end: three girar cycles, one settle, one decide, then another right turn.
    do_reset();
    sensors(1'b1, 1'b1, 1'b0, 1'b0);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dead_girar", cmd(), 32'h2);
    end
    tick();
    check("dead_settle", cmd(), 32'h0);
    tick();
    check("dead_decide", cmd(), 32'h0);
    tick();
    check("dead_turn2", cmd(), 32'h2);
    check("dead_moves", 32'(moves), 32'h0);

    // Barrier: two 3-cycle bursts; enable dropped mid-burst does not abort it.
    do_reset();
    sensors(1'b1, 1'b1, 1'b0, 1'b1);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bar1_remover", cmd(), 32'h1);
    end
    tick();
    check("bar1_settle", cmd(), 32'h0);
    tick();
    check("bar1_decide", cmd(), 32'h0);
    tick();
    check("bar2_remover", cmd(), 32'h1);
    enable = 1'b0;
    tick();
    check("bar2_remover", cmd(), 32'h1);
    sensors(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    check("bar2_remover", cmd(), 32'h1);
    tick();
    check("bar2_settle", cmd(), 32'h0);
    tick();
    check("bar2_decide", cmd(), 32'h0);
    tick();
    check("bar_enable_low", cmd(), 32'h0);
    enable = 1'b1;
    tick();
    check("bar_fwd", cmd(), 32'h4);
    check("bar_moves", 32'(moves), 32'h1);

    // Async reset mid-burst: remover drops without a clock edge, FSM restarts from IDLE.
    do_reset();
    sensors(1'b1, 1'b1, 1'b0, 1'b1);
    enable = 1'b1;
    tick();
    tick();
    tick();
    check("arst_pre", cmd(), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_cmd", cmd(), 32'h0);
    check("arst_flags", 32'({done, stuck}), 32'h0);
    check("arst_moves", 32'(moves), 32'h0);
    tick();
    reset  = 1'b0;
    enable = 1'b0;
    tick();
    check("arst_idle", cmd(), 32'h0);
    enable = 1'b1;
    tick();
    check("arst_decide", cmd(), 32'h0);
    tick();
    check("arst_remover", cmd(), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
